// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared pipeline control types and constants
package arm_pipe_pkg;

    localparam int REG_IDX_W = 4;
    localparam int WAIT_W    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sram_state_t;

    // Ordered so a larger value always wins; the forwarding unit uses the same ranking.
    typedef enum logic [1:0] {
        PRI_NONE   = 2'd0,
        PRI_HAZARD = 2'd1,
        PRI_BRANCH = 2'd2,
        PRI_STALL  = 2'd3
    } ctrl_pri_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
interface pipe_hazard_ctrl_if
    import arm_pipe_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [REG_IDX_W-1:0] id_src1;
    logic                 id_src1_vld;
    logic [REG_IDX_W-1:0] id_src2;
    logic                 id_two_src;
    logic [REG_IDX_W-1:0] exe_dest;
    logic                 exe_wb_en;
    logic                 exe_mem_r_en;
    logic [REG_IDX_W-1:0] mem_dest;
    logic                 mem_wb_en;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic                 fwd_en;
    logic                 exe_branch_taken;
    logic                 if_freeze;
    logic                 if_flush;
    logic                 id_freeze;
    logic                 id_flush;
    logic                 exe_freeze;
    logic                 mem_freeze;
    logic                 sram_ready;
    logic [CNT_W-1:0]     bubble_cnt;
    logic [CNT_W-1:0]     stall_cnt;

    modport master (
        output id_src1, id_src1_vld, id_src2, id_two_src,
        output exe_dest, exe_wb_en, exe_mem_r_en,
        output mem_dest, mem_wb_en, mem_r_en, mem_w_en,
        output fwd_en, exe_branch_taken,
        input  if_freeze, if_flush, id_freeze, id_flush, exe_freeze, mem_freeze,
        input  sram_ready, bubble_cnt, stall_cnt
    );

    modport slave (
        input  id_src1, id_src1_vld, id_src2, id_two_src,
        input  exe_dest, exe_wb_en, exe_mem_r_en,
        input  mem_dest, mem_wb_en, mem_r_en, mem_w_en,
        input  fwd_en, exe_branch_taken,
        output if_freeze, if_flush, id_freeze, id_flush, exe_freeze, mem_freeze,
        output sram_ready, bubble_cnt, stall_cnt
    );
endinterface

// File: rtl/sram_wait_fsm.sv
// rtl/sram_wait_fsm.sv - MEM-stage SRAM wait-state sequencer
module sram_wait_fsm
    import arm_pipe_pkg::*;
#(
    parameter int SRAM_WAIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_acc,
    output logic mem_stall,
    output logic sram_ready
);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = (SRAM_WAIT > 0) ? WAIT_W'(SRAM_WAIT - 1) : '0;

    sram_state_t       state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              stall_raw, ready_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        stall_raw = 1'b0;
        ready_raw = 1'b0;
        if (state == IDLE) begin
            if (mem_acc) begin
                if (SRAM_WAIT == 0) begin
                    ready_raw = 1'b1;
                end else begin
                    stall_raw = 1'b1;
                    wait_nxt  = WAIT_LOAD;
                    state_nxt = BUSY;
                end
            end
        end else begin
            if (wait_cnt != '0) begin
                stall_raw = 1'b1;
                wait_nxt  = wait_cnt - 1'b1;
            end else begin
                ready_raw = 1'b1;
                state_nxt = IDLE;
            end
        end
    end

    // The IDLE decode is combinational from mem_acc, so mask it while reset is held.
    assign mem_stall  = rst_n & stall_raw;
    assign sram_ready = rst_n & ready_raw;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline freeze/flush controller with bubble and stall counters
module pipe_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int SRAM_WAIT = 3,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_hazard_ctrl_if.slave   bus
);
    logic      mem_stall;
    logic      exe_prod, mem_prod;
    logic      src1_hit, src2_hit, data_hz;
    ctrl_pri_t pri;
    logic [CNT_W-1:0] bubble_q, stall_q;

    sram_wait_fsm #(.SRAM_WAIT(SRAM_WAIT)) u_sram_wait_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_acc    (bus.mem_r_en | bus.mem_w_en),
        .mem_stall  (mem_stall),
        .sram_ready (bus.sram_ready)
    );

    // With forwarding on, only a load in EXE cannot be bypassed in time.
    assign exe_prod = bus.fwd_en ? (bus.exe_wb_en & bus.exe_mem_r_en) : bus.exe_wb_en;
    assign mem_prod = ~bus.fwd_en & bus.mem_wb_en;

    assign src1_hit = bus.id_src1_vld &
                      ((exe_prod & (bus.exe_dest == bus.id_src1)) |
                       (mem_prod & (bus.mem_dest == bus.id_src1)));
    assign src2_hit = bus.id_two_src &
                      ((exe_prod & (bus.exe_dest == bus.id_src2)) |
                       (mem_prod & (bus.mem_dest == bus.id_src2)));
    assign data_hz  = src1_hit | src2_hit;

    always_comb begin
        pri = PRI_NONE;
        if (!rst_n)                    pri = PRI_NONE;
        else if (mem_stall)            pri = PRI_STALL;
        else if (bus.exe_branch_taken) pri = PRI_BRANCH;
        else if (data_hz)              pri = PRI_HAZARD;
    end

    always_comb begin
        bus.if_freeze  = 1'b0;
        bus.if_flush   = 1'b0;
        bus.id_freeze  = 1'b0;
        bus.id_flush   = 1'b0;
        bus.exe_freeze = 1'b0;
        bus.mem_freeze = 1'b0;
        case (pri)
            PRI_STALL: begin
                bus.if_freeze  = 1'b1;
                bus.id_freeze  = 1'b1;
                bus.exe_freeze = 1'b1;
                bus.mem_freeze = 1'b1;
            end
            PRI_BRANCH: begin
                bus.if_flush = 1'b1;
                bus.id_flush = 1'b1;
            end
            PRI_HAZARD: begin
                bus.if_freeze = 1'b1;
                bus.id_flush  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_q <= '0;
            stall_q  <= '0;
        end else begin
            if (pri == PRI_HAZARD && bubble_q != '1)
                bubble_q <= bubble_q + CNT_W'(1);
            if (pri == PRI_STALL && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign bus.bubble_cnt = bubble_q;
    assign bus.stall_cnt  = stall_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage ARM core. It produces the freeze and flush controls that every stage register consumes, including the ID/EX register.
- Freeze comes from two sources: RAW data hazards detected in ID, and a multi-cycle SRAM wait-state FSM in the MEM stage.
- Flush comes from a taken branch resolved in EXE.
- A saturating bubble counter supports performance debug.

Parameters:
SRAM_WAIT, 3, extra cycles a MEM-stage SRAM access holds MEM (legal range 0..15)
CNT_W, 16, width of saturating bubble/stall counters

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
id_src1  in  4  Rn index of instruction in ID
id_src1_vld  in  1  ID instruction reads Rn
id_src2  in  4  Rm/Rd-store index of instruction in ID
id_two_src  in  1  ID instruction reads second source
exe_dest  in  4  destination of instruction in EXE
exe_wb_en  in  1  EXE instruction writes back
exe_mem_r_en  in  1  EXE instruction is a load
mem_dest  in  4  destination of instruction in MEM
mem_wb_en  in  1  MEM instruction writes back
mem_r_en  in  1  MEM instruction reads SRAM
mem_w_en  in  1  MEM instruction writes SRAM
fwd_en  in  1  forwarding unit enabled
exe_branch_taken  in  1  branch resolved taken in EXE
if_freeze  out  1  hold PC and IF/ID register
if_flush  out  1  clear IF/ID register
id_freeze  out  1  hold ID/EX register
id_flush  out  1  clear ID/EX register (bubble)
exe_freeze  out  1  hold EX/MEM register
mem_freeze  out  1  hold MEM/WB register
sram_ready  out  1  current MEM access completes this cycle
bubble_cnt  out  CNT_W  saturating count of bubbles inserted
stall_cnt  out  CNT_W  saturating count of SRAM stall cycles

Behaviour:
- Reset (rst_n=0, async):
  - FSM goes to IDLE, wait counter=0, bubble_cnt=0, stall_cnt=0.
  - All freeze/flush outputs are 0 and sram_ready=0 while in reset.
  - Reset mid-access abandons the access; no ready pulse is emitted.
- Hazard detection (combinational from inputs):
  - src1_hit = id_src1_vld and id_src1 matches a producer.
  - src2_hit = id_two_src and id_src2 matches a producer.
  - With fwd_en=0, producers are (exe_wb_en, exe_dest) and (mem_wb_en, mem_dest).
  - With fwd_en=1, the only producer is EXE when exe_wb_en and exe_mem_r_en (load-use).
  - data_hz = src1_hit or src2_hit.
- SRAM FSM, states IDLE and BUSY; mem_acc = mem_r_en or mem_w_en:
  - IDLE with mem_acc and SRAM_WAIT>0: mem_stall=1; load wait counter with SRAM_WAIT-1; go to BUSY.
  - IDLE with mem_acc and SRAM_WAIT=0: no stall; sram_ready=1 in the same cycle.
  - BUSY with counter>0: mem_stall=1; decrement the counter.
  - BUSY with counter=0: mem_stall=0; sram_ready=1; go to IDLE.
  - Net timing: the MEM instruction occupies MEM for SRAM_WAIT+1 cycles, with exactly SRAM_WAIT frozen cycles.
  - Back-to-back accesses: the next instruction reaches MEM in the cycle after ready and starts a fresh IDLE→BUSY sequence.
- Output priority (highest first):
  1. mem_stall: all four freezes=1; all flushes=0. A pending branch or hazard is held and re-evaluated after the stall.
  2. exe_branch_taken: if_flush=1 and id_flush=1; freezes=0; data_hz is ignored.
  3. data_hz: if_freeze=1 and id_flush=1 (bubble into ID/EX); exe_freeze=0 and mem_freeze=0.
  4. Otherwise all outputs are 0.
- id_freeze is 1 only under mem_stall.
- Counters:
  - bubble_cnt increments in each cycle that id_flush=1 due to data_hz (priority 3 only).
  - stall_cnt increments in each cycle that mem_stall=1.
  - Both saturate at all-ones; no wrap.
- Latency: all freeze/flush outputs are combinational from inputs and FSM state (zero-cycle). Counters update on the next clk edge.

Decomposition:
- Shared package arm_pipe_pkg:
  - REG_IDX_W=4.
  - sram_state_t enum {IDLE, BUSY}.
  - Priority constants shared with the forwarding unit.
- Sub-module sram_wait_fsm:
  - Owns the state, the wait counter and sram_ready.
  - Exports mem_stall to this block.
- Hazard compare and priority mux stay in pipe_hazard_ctrl.

Test Plan:
1. fwd_en=0, exe_wb_en=1, exe_dest=3, id_src1=3, id_src1_vld=1 → if_freeze=1, id_flush=1, other freezes 0; bubble_cnt increments by 1 per cycle held.
2. fwd_en=1, same setup with exe_mem_r_en=0 → no hazard (all outputs 0); set exe_mem_r_en=1 → one bubble.
3. SRAM_WAIT=3, mem_r_en pulsed in cycle T and held until ready → all freezes=1 in T..T+2; sram_ready=1 in T+3; stall_cnt=3.
4. exe_branch_taken=1 together with data_hz=1 → if_flush=1, id_flush=1, if_freeze=0; bubble_cnt unchanged.
5. exe_branch_taken=1 during an SRAM stall → flushes stay 0 until the stall ends, then if_flush=1 and id_flush=1 in the release cycle.
6. rst_n deasserted-to-0 mid-BUSY → outputs go 0 immediately (async); after release, FSM in IDLE and counters read 0; also check SRAM_WAIT=0 gives ready with no stall.
